branch_redirect_ctrl: RTL
=========================

// Module: branch_redirect_ctrl
// PURPOSE
// Resolves control-transfer instructions (B-type, JAL, JALR) handed over by decode and sequences the PC redirect.
// - Extracts and sign-extends the immediate, evaluates the branch condition, computes the target.
// - Drives a held redirect request to fetch; pulses pipeline flush on acceptance.
// - Supplies the link value (pc+4) for jumps; flags misaligned targets and illegal funct3.
// - Sits between decode/regfile read and the fetch PC register.
// PARAMETERS
// XLEN      32  datapath width (PC, operands, target)
// CNT_W     32  width of branch/taken performance counters
// PORTS
// clk            in   1      single clock, rising edge
// rst            in   1      asynchronous, active-high reset
// instr_valid    in   1      decode presents an instruction
// instr_ready    out  1      block accepts (high only in IDLE)
// instr          in   32     raw instruction word
// pc             in   XLEN   PC of instr
// rs1_val        in   XLEN   rs1 operand
// rs2_val        in   XLEN   rs2 operand
// redir_valid    out  1      redirect request to fetch
// redir_ready    in   1      fetch accepts redirect
// redir_pc       out  XLEN   redirect target, stable while redir_valid
// flush          out  1      1-cycle pulse on redirect handshake
// done           out  1      1-cycle pulse: instruction resolved
// rd_we          out  1      with done: write link value (JAL/JALR)
// rd_wdata       out  XLEN   pc+4 of resolved instruction
// exc_misalign   out  1      1-cycle pulse: taken target[1]!=0
// exc_illegal    out  1      1-cycle pulse: B-type funct3 010/011
// branch_cnt     out  CNT_W  resolved control-transfer count
// taken_cnt      out  CNT_W  taken count
// BEHAVIOUR
// - Clock/reset: one clock; reset is asynchronous and active-high.
// - On reset: state=IDLE, instr_ready=1, every other output (including counters) =0.
// - FSM states: IDLE, EVAL, REDIR, TRAP.
// - IDLE: accept when instr_valid&&instr_ready; register instr, pc, rs1_val, rs2_val; go to EVAL.
// - EVAL: one cycle. Registers imm, cond and target.
//   - B-type: imm={i[31],i[7],i[30:25],i[11:8],0} sign-extended; target=pc+imm.
//   - JAL: imm={i[31],i[19:12],i[20],i[30:21],0} sign-extended; target=pc+imm; cond=1.
//   - JALR: target=(rs1+sext(i[31:20]))&~1; cond=1.
//   - B-type cond by funct3: BEQ/BNE/BLT/BGE signed, BLTU/BGEU unsigned.
//   - funct3 010/011 or any other opcode: cond=0, no redirect.
// - Transitions from EVAL:
//   - illegal funct3 -> TRAP with exc_illegal.
//   - cond && target[1] -> TRAP with exc_misalign.
//   - cond -> REDIR.
//   - else -> IDLE, pulsing done (rd_we=0).
// - REDIR: redir_valid=1 with redir_pc held stable.
//   - On redir_ready: same cycle flush=1, done=1, rd_we=1 for jumps; then -> IDLE.
//   - No timeout; backpressure is unbounded.
// - TRAP: one cycle. exc_* pulse with done=1, no redirect, no link write -> IDLE.
// - Latency (accept in cycle N): not-taken done in N+2; redir_valid earliest N+2; accept again at N+3.
// - Counters (+1, wrap at 2^CNT_W-1 -> 0):
//   - branch_cnt on each done for B/JAL/JALR, including traps.
//   - taken_cnt on redirect handshake only.
// - Arithmetic is XLEN-bit modular; target wrap past 0xFFFFFFFF is not flagged.
// - Reset mid-operation (any state): in-flight instruction dropped, no redirect/flush/done.
// - instr_valid outside IDLE is ignored (instr_ready=0); decode holds its inputs.
// STRUCTURE
// - Package riscv_pkg holds:
//   - opcode constants OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111.
//   - funct3 enum br_f3_e.
//   - FSM enum br_state_e.
// - Sub-module branch_imm_gen: combinational imm extract/sign-extend for B/J/I formats, selected by opcode.
// - Compare logic and FSM are in this module.
// TESTING
// - BEQ pc=0x100, imm=+8, rs1=rs2=5: redir_pc=0x108, flush pulse on handshake; taken_cnt=1.
// - BNE rs1=rs2=5: done at N+2, no redir_valid, no flush; branch_cnt=1, taken_cnt=0.
// - BLT pc=0x100, imm=-4, rs1=0xFFFFFFFF, rs2=1: taken, redir_pc=0xFC.
//   - BLTU same operands: not taken.
// - JALR rs1=0x201, imm=0: target 0x200, rd_wdata=pc+4, rd_we with done.
//   - JALR rs1=0x202: exc_misalign pulse, no redirect.
// - redir_ready held low 3 cycles: redir_valid/redir_pc stable; flush only on the 4th cycle.
//   - Funct3=010: exc_illegal pulse.
// - Assert rst while in REDIR: outputs and counters 0 immediately; next accept works from IDLE.

Source files
------------

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared RISC-V control-transfer definitions: opcodes, branch funct3 codes, redirect FSM states.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_REDIR = 2'd2,
    ST_TRAP  = 2'd3
  } br_state_e;

  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Decode-side instruction handoff, fetch-side redirect handshake and resolve/status outputs.
interface branch_redirect_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic             redir_valid;
  logic             redir_ready;
  logic [XLEN-1:0]  redir_pc;
  logic             flush;
  logic             done;
  logic             rd_we;
  logic [XLEN-1:0]  rd_wdata;
  logic             exc_misalign;
  logic             exc_illegal;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport slave (
    input  instr_valid, instr, pc, rs1_val, rs2_val, redir_ready,
    output instr_ready, redir_valid, redir_pc, flush, done, rd_we, rd_wdata,
           exc_misalign, exc_illegal, branch_cnt, taken_cnt
  );

  modport master (
    output instr_valid, instr, pc, rs1_val, rs2_val, redir_ready,
    input  instr_ready, redir_valid, redir_pc, flush, done, rd_we, rd_wdata,
           exc_misalign, exc_illegal, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl_imm_gen.sv
// Combinational immediate extraction and sign extension for B, J and I (JALR) formats.
module branch_imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_i;

  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_BRANCH: imm = imm_b;
      OP_JAL:    imm = imm_j;
      OP_JALR:   imm = imm_i;
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves B-type/JAL/JALR: evaluates condition and target, then holds a redirect to fetch
// until accepted, pulsing flush/done; traps on illegal funct3 or misaligned taken target.
module branch_redirect_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  branch_redirect_ctrl_if.slave bus
);

  br_state_e        state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  rs1_q, rs1_d;
  logic [XLEN-1:0]  rs2_q, rs2_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic [XLEN-1:0]  link_q, link_d;
  logic             illegal_q, illegal_d;
  logic             misalign_q, misalign_d;
  logic             nt_done_q, nt_done_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             is_branch;
  logic             is_jal;
  logic             is_jalr;
  logic             is_jump;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  base;
  logic [XLEN-1:0]  sum;
  logic [XLEN-1:0]  target;
  logic             cond;
  logic             illegal;
  logic             handshake;
  logic             done;

  assign opcode    = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_jump   = is_jal || is_jalr;

  branch_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr_q),
    .imm   (imm)
  );

  // JALR adds to rs1 and clears bit 0; everything else is PC-relative.
  assign base   = is_jalr ? rs1_q : pc_q;
  assign sum    = base + imm;
  assign target = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    if (is_branch) begin
      case (funct3)
        F3_BEQ:  cond = (rs1_q == rs2_q);
        F3_BNE:  cond = (rs1_q != rs2_q);
        F3_BLT:  cond = ($signed(rs1_q) <  $signed(rs2_q));
        F3_BGE:  cond = ($signed(rs1_q) >= $signed(rs2_q));
        F3_BLTU: cond = (rs1_q <  rs2_q);
        F3_BGEU: cond = (rs1_q >= rs2_q);
        default: illegal = 1'b1;
      endcase
    end else if (is_jump) begin
      cond = 1'b1;
    end
  end

  assign handshake = (state_q == ST_REDIR) && bus.redir_ready;
  assign done      = handshake || (state_q == ST_TRAP) || nt_done_q;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    target_d   = target_q;
    link_d     = link_q;
    illegal_d  = illegal_q;
    misalign_d = misalign_q;
    nt_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          pc_d    = bus.pc;
          rs1_d   = bus.rs1_val;
          rs2_d   = bus.rs2_val;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        target_d   = target;
        link_d     = pc_q + XLEN'(4);
        illegal_d  = illegal;
        misalign_d = cond && target[1];
        if (illegal || (cond && target[1])) begin
          state_d = ST_TRAP;
        end else if (cond) begin
          state_d = ST_REDIR;
        end else begin
          state_d   = ST_IDLE;
          nt_done_d = 1'b1;
        end
      end
      ST_REDIR: begin
        if (bus.redir_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // instr_q is still the resolved instruction in its done cycle, so the opcode check is valid there.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (done && is_ctrl_op(opcode)) begin
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    end
    if (handshake) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      target_q     <= '0;
      link_q       <= '0;
      illegal_q    <= 1'b0;
      misalign_q   <= 1'b0;
      nt_done_q    <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      target_q     <= target_d;
      link_q       <= link_d;
      illegal_q    <= illegal_d;
      misalign_q   <= misalign_d;
      nt_done_q    <= nt_done_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign bus.instr_ready  = (state_q == ST_IDLE);
  assign bus.redir_valid  = (state_q == ST_REDIR);
  assign bus.redir_pc     = target_q;
  assign bus.flush        = handshake;
  assign bus.done         = done;
  assign bus.rd_we        = handshake && is_jump;
  assign bus.rd_wdata     = link_q;
  assign bus.exc_misalign = (state_q == ST_TRAP) && misalign_q;
  assign bus.exc_illegal  = (state_q == ST_TRAP) && illegal_q;
  assign bus.branch_cnt   = branch_cnt_q;
  assign bus.taken_cnt    = taken_cnt_q;

endmodule
